// File: rtl/beehive_vr_pkg.sv
// Shared constants and types for the prepare log-write path.
// Optional tail masking is enabled by defining PREP_LOG_WR_TAIL_MASK_EN.
package beehive_vr_pkg;

  localparam int PREPARE_HDR_BYTES = 16;
  // log2 of the byte count of one 512-bit log line
  localparam int LOG_W_BYTES_W = 6;

  typedef enum logic [2:0] {
    PLW_IDLE,
    PLW_FIRST,
    PLW_STREAM,
    PLW_FLUSH,
    PLW_DONE
  } prep_log_wr_state_e;

endpackage

// File: rtl/prepare_log_realign.sv
// Splices the carried residue with the head of the next flit into one log line.
// With PREP_LOG_WR_TAIL_MASK_EN defined, bytes past the payload end of the final line are zeroed.
module prepare_log_realign #(
  parameter int B   = 64,
  parameter int OFF = 16,
  parameter int TW  = 6
) (
  input  logic [(B-OFF)*8-1:0] residue_i,
  input  logic [OFF*8-1:0]     flit_top_i,
  input  logic                 flush_i,
  input  logic                 last_i,
  input  logic [TW-1:0]        tail_bytes_i,
  output logic [B*8-1:0]       line_o
);

  always_comb begin
    line_o = flush_i ? {residue_i, {(OFF*8){1'b0}}} : {residue_i, flit_top_i};
`ifdef PREP_LOG_WR_TAIL_MASK_EN
    // tail_bytes == 0 means the payload fills the final line exactly
    if (last_i && (tail_bytes_i != '0)) begin
      for (int p = 0; p < B; p++) begin
        if (p >= int'(tail_bytes_i)) line_o[B*8-1-8*p -: 8] = 8'h00;
      end
    end
`endif
  end

`ifndef PREP_LOG_WR_TAIL_MASK_EN
  logic unused_mask_inputs;
  assign unused_mask_inputs = ^{last_i, tail_bytes_i};
`endif

endmodule

// File: rtl/prepare_log_wr.sv
// Realigns a Prepare payload flit stream onto log-line boundaries and writes it to the log data memory.
// Build option: PREP_LOG_WR_TAIL_MASK_EN zeroes trailing bytes of the final line.
module prepare_log_wr
  import beehive_vr_pkg::*;
#(
  parameter int NOC_DATA_W        = 512,
  parameter int PAYLOAD_OFF_BYTES = PREPARE_HDR_BYTES,
  parameter int LOG_DEPTH_W       = 10,
  parameter int LEN_W             = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_val,
  output logic                   start_rdy,
  input  logic [LOG_DEPTH_W-1:0] start_addr,
  input  logic [LEN_W-1:0]       start_len,
  input  logic                   in_data_val,
  input  logic [NOC_DATA_W-1:0]  in_data,
  input  logic                   in_data_last,
  output logic                   in_data_rdy,
  output logic                   log_wr_val,
  output logic [LOG_DEPTH_W-1:0] log_wr_addr,
  output logic [NOC_DATA_W-1:0]  log_wr_data,
  output logic                   log_incr_wr_addr,
  output logic                   done_val,
  input  logic                   done_rdy,
  output logic [LOG_DEPTH_W:0]   done_lines,
  output prep_log_wr_state_e     dbg_state
);

  localparam int B     = NOC_DATA_W / 8;
  localparam int OFF   = PAYLOAD_OFF_BYTES;
  localparam int RES_W = (B - OFF) * 8;
  localparam int CW    = LEN_W + 1;
  localparam int TW    = $clog2(B);

  // Handshakes: a transfer happens on a rising edge where val and rdy are both high;
  // the sender holds its payload stable while val is high and rdy is low.

  prep_log_wr_state_e state_q, state_d;
  logic [LOG_DEPTH_W-1:0] cur_addr_q, cur_addr_d;
  logic [TW-1:0]          tail_q, tail_d;
  logic [CW-1:0]          l_q, l_d, f_q, f_d;
  logic [CW-1:0]          flit_cnt_q, flit_cnt_d;
  logic [CW-1:0]          lines_q, lines_d;
  logic [RES_W-1:0]       residue_q, residue_d;
  logic                   wr_val_q, wr_val_d;
  logic [LOG_DEPTH_W-1:0] wr_addr_q, wr_addr_d;
  logic [NOC_DATA_W-1:0]  wr_data_q, wr_data_d;

  logic [CW-1:0]          len_ext;
  logic [CW-1:0]          l_calc, f_calc;
  logic [NOC_DATA_W-1:0]  line;
  logic                   flush_sel, last_line;

  assign len_ext = CW'(start_len);
  assign l_calc  = (len_ext + CW'(B - 1)) / CW'(B);
  assign f_calc  = (len_ext + CW'(OFF + B - 1)) / CW'(B);

  assign flush_sel = (state_q == PLW_FLUSH);
  assign last_line = flush_sel || ((lines_q + CW'(1)) == l_q);

  prepare_log_realign #(.B(B), .OFF(OFF), .TW(TW)) u_realign (
    .residue_i    (residue_q),
    .flit_top_i   (in_data[NOC_DATA_W-1 -: OFF*8]),
    .flush_i      (flush_sel),
    .last_i       (last_line),
    .tail_bytes_i (tail_q),
    .line_o       (line)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= PLW_IDLE;
      cur_addr_q <= '0;
      tail_q     <= '0;
      l_q        <= '0;
      f_q        <= '0;
      flit_cnt_q <= '0;
      lines_q    <= '0;
      residue_q  <= '0;
      wr_val_q   <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      tail_q     <= tail_d;
      l_q        <= l_d;
      f_q        <= f_d;
      flit_cnt_q <= flit_cnt_d;
      lines_q    <= lines_d;
      residue_q  <= residue_d;
      wr_val_q   <= wr_val_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    tail_d      = tail_q;
    l_d         = l_q;
    f_d         = f_q;
    flit_cnt_d  = flit_cnt_q;
    lines_d     = lines_q;
    residue_d   = residue_q;
    wr_val_d    = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    in_data_rdy = 1'b0;
    case (state_q)
      PLW_IDLE: begin
        if (start_val) begin
          cur_addr_d = start_addr;
          tail_d     = TW'(start_len % LEN_W'(B));
          l_d        = l_calc;
          f_d        = f_calc;
          flit_cnt_d = '0;
          lines_d    = '0;
          state_d    = PLW_FIRST;
        end
      end
      PLW_FIRST: begin
        in_data_rdy = 1'b1;
        if (in_data_val) begin
          residue_d  = in_data[RES_W-1:0];
          flit_cnt_d = CW'(1);
          if (l_q == '0)          state_d = PLW_DONE;
          else if (f_q == CW'(1)) state_d = PLW_FLUSH;
          else                    state_d = PLW_STREAM;
        end
      end
      PLW_STREAM: begin
        in_data_rdy = 1'b1;
        if (in_data_val) begin
          wr_val_d   = 1'b1;
          wr_addr_d  = cur_addr_q;
          wr_data_d  = line;
          cur_addr_d = cur_addr_q + 1'b1;
          residue_d  = in_data[RES_W-1:0];
          lines_d    = lines_q + CW'(1);
          flit_cnt_d = flit_cnt_q + CW'(1);
          // Last flit: either it finished the final line, or a residue-only line remains
          if ((flit_cnt_q + CW'(1)) == f_q) begin
            state_d = ((lines_q + CW'(1)) == l_q) ? PLW_DONE : PLW_FLUSH;
          end
        end
      end
      PLW_FLUSH: begin
        wr_val_d   = 1'b1;
        wr_addr_d  = cur_addr_q;
        wr_data_d  = line;
        cur_addr_d = cur_addr_q + 1'b1;
        lines_d    = lines_q + CW'(1);
        state_d    = PLW_DONE;
      end
      PLW_DONE: begin
        if (done_rdy) state_d = PLW_IDLE;
      end
      default: state_d = PLW_IDLE;
    endcase
  end

  assign start_rdy        = (state_q == PLW_IDLE) && !rst;
  assign log_wr_val       = wr_val_q;
  assign log_incr_wr_addr = wr_val_q;
  assign log_wr_addr      = wr_addr_q;
  assign log_wr_data      = wr_data_q;
  assign done_val         = (state_q == PLW_DONE);
  assign done_lines       = lines_q[LOG_DEPTH_W:0];
  assign dbg_state        = state_q;

  logic unused_inputs;
  assign unused_inputs = ^{in_data_last, lines_q[CW-1:LOG_DEPTH_W+1]};

endmodule

// File: tb/tb_prepare_log_wr.sv
// Randomized scoreboard bench for prepare_log_wr (B=64, OFF=16); mirrors PREP_LOG_WR_TAIL_MASK_EN.
module tb_prepare_log_wr;
  import beehive_vr_pkg::*;

  localparam int W   = 512;
  localparam int B   = 64;
  localparam int OFF = 16;
  localparam int DW  = 10;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start_val = 1'b0;
  logic           start_rdy;
  logic [DW-1:0]  start_addr = '0;
  logic [15:0]    start_len = '0;
  logic           in_data_val = 1'b0;
  logic [W-1:0]   in_data = '0;
  logic           in_data_last = 1'b0;
  logic           in_data_rdy;
  logic           log_wr_val;
  logic [DW-1:0]  log_wr_addr;
  logic [W-1:0]   log_wr_data;
  logic           log_incr_wr_addr;
  logic           done_val;
  logic           done_rdy = 1'b0;
  logic [DW:0]    done_lines;
  prep_log_wr_state_e dbg_state;

  prepare_log_wr dut (
    .clk(clk), .rst(rst),
    .start_val(start_val), .start_rdy(start_rdy),
    .start_addr(start_addr), .start_len(start_len),
    .in_data_val(in_data_val), .in_data(in_data),
    .in_data_last(in_data_last), .in_data_rdy(in_data_rdy),
    .log_wr_val(log_wr_val), .log_wr_addr(log_wr_addr),
    .log_wr_data(log_wr_data), .log_incr_wr_addr(log_incr_wr_addr),
    .done_val(done_val), .done_rdy(done_rdy),
    .done_lines(done_lines), .dbg_state(dbg_state)
  );

  // ---------------- clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state
  logic [W-1:0]  exp_q[$];
  logic [DW-1:0] exp_addr_q[$];
  int            exp_cyc_q[$];
  int            tests = 0;
  int            fails = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- monitor
  always @(negedge clk) begin
    check("incr_eq_val", W'(log_incr_wr_addr), W'(log_wr_val));
    if (log_wr_val === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", W'(log_wr_val), W'(0));
      end else begin
        logic [W-1:0]  ed;
        logic [DW-1:0] ea;
        ed = exp_q.pop_front();
        ea = exp_addr_q.pop_front();
        check("wr_data", log_wr_data, ed);
        check("wr_addr", W'(log_wr_addr), W'(ea));
        if (exp_cyc_q.size() == 0) check("wr_cycle_unscheduled", W'(cyc), W'(-1));
        else check("wr_cycle", W'(cyc), W'(exp_cyc_q.pop_front()));
      end
    end
  end

  // ---------------- driver: one full job (model + stimulus + done handshake)
  task automatic run_job(input logic [DW-1:0] addr, input int len, input bit toggle,
                         input int done_wait, input bit ff_flit1, input int abort_after);
    int L, F, idx, t;
    bit got, phase;
    logic [7:0] s[];
    L = (len + B - 1) / B;
    F = (OFF + len + B - 1) / B;
    s = new[F * B];
    for (int i = 0; i < F * B; i++) begin
      s[i] = 8'($urandom_range(0, 255));
      if (ff_flit1 && i >= B && i < 2 * B) s[i] = 8'hFF;
    end
    // Reference: line k holds stream bytes OFF+64k .. OFF+64k+63, zero past the last flit
    for (int k = 0; k < L; k++) begin
      logic [W-1:0] ln;
      ln = '0;
      for (int j = 0; j < B; j++) begin
        int pos;
        logic [7:0] b;
        pos = OFF + B * k + j;
        b = (pos < F * B) ? s[pos] : 8'h00;
`ifdef PREP_LOG_WR_TAIL_MASK_EN
        if (k == L - 1 && (len % B) != 0 && j >= (len % B)) b = 8'h00;
`endif
        ln[W-1-8*j -: 8] = b;
      end
      exp_q.push_back(ln);
      exp_addr_q.push_back(DW'(addr + DW'(k)));
    end

    @(posedge clk); #1;
    start_val = 1'b1; start_addr = addr; start_len = 16'(len);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk); got = start_rdy;
      @(posedge clk); #1;
    end
    start_val = 1'b0;
    check("start_accept", W'(got), W'(1));

    idx = 0; t = 0; phase = 1'b1;
    while (idx < F && t < 400 && !(abort_after > 0 && idx == abort_after)) begin
      in_data_val = toggle ? phase : 1'b1;
      for (int j = 0; j < B; j++) in_data[W-1-8*j -: 8] = s[B * idx + j];
      in_data_last = (idx == F - 1);
      @(negedge clk);
      if (in_data_val && in_data_rdy) begin
        if (idx >= 1 && idx - 1 < L) exp_cyc_q.push_back(cyc + 1);
        if (idx == F - 1 && F == L) exp_cyc_q.push_back(cyc + 2);
        idx++;
      end
      @(posedge clk); #1;
      phase = ~phase; t++;
    end
    in_data_val = 1'b0; in_data_last = 1'b0;

    if (abort_after > 0) begin
      repeat (2) begin @(posedge clk); #1; end
      check("abort_pending_lines", W'(exp_q.size()), W'(L - (abort_after - 1)));
      rst = 1'b1;
      exp_q.delete(); exp_addr_q.delete(); exp_cyc_q.delete();
      repeat (2) begin
        @(negedge clk);
        check("rst_wr_val", W'(log_wr_val), W'(0));
        check("rst_done_val", W'(done_val), W'(0));
        @(posedge clk); #1;
      end
      rst = 1'b0;
      repeat (8) begin
        @(negedge clk);
        check("post_rst_state", W'(dbg_state), W'(PLW_IDLE));
        check("post_rst_start_rdy", W'(start_rdy), W'(1));
        @(posedge clk); #1;
      end
      return;
    end

    check("flits_consumed", W'(idx), W'(F));
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk); got = done_val;
      if (!got) begin @(posedge clk); #1; end
    end
    check("done_seen", W'(got), W'(1));
    check("done_lines", W'(done_lines), W'(L));
    check("start_rdy_in_done", W'(start_rdy), W'(0));
    for (int w = 0; w < done_wait; w++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("done_held", W'(done_val), W'(1));
      check("start_rdy_held_low", W'(start_rdy), W'(0));
    end
    @(posedge clk); #1; done_rdy = 1'b1;
    @(negedge clk);
    check("done_before_rdy_edge", W'(done_val), W'(1));
    @(posedge clk); #1; done_rdy = 1'b0;
    @(negedge clk);
    check("done_dropped", W'(done_val), W'(0));
    check("start_rdy_back", W'(start_rdy), W'(1));
    check("exp_drained", W'(exp_q.size()), W'(0));
  endtask

  // ---------------- main sequence
  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_log_wr_val", W'(log_wr_val), W'(0));
    check("rst_log_wr_addr", W'(log_wr_addr), W'(0));
    check("rst_log_wr_data", log_wr_data, W'(0));
    check("rst_in_data_rdy", W'(in_data_rdy), W'(0));
    check("rst_done_val", W'(done_val), W'(0));
    check("rst_done_lines", W'(done_lines), W'(0));
    check("rst_state", W'(dbg_state), W'(PLW_IDLE));
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("idle_start_rdy", W'(start_rdy), W'(1));

    run_job(10'd5,    48,  1'b0, 0, 1'b0, 0);  // single flit, FLUSH line
    run_job(10'd5,    64,  1'b0, 0, 1'b0, 0);  // exact line, no FLUSH
    run_job(10'd7,    0,   1'b0, 1, 1'b0, 0);  // empty payload
    run_job(10'd1023, 200, 1'b0, 0, 1'b0, 0);  // address wrap
    run_job(10'd100,  300, 1'b1, 5, 1'b0, 0);  // bubbly input, slow done consumer
    run_job(10'd9,    50,  1'b0, 0, 1'b1, 0);  // tail bytes from 0xFF flit
    for (int r = 0; r < 8; r++) begin
      run_job(DW'($urandom_range(0, 1023)), int'($urandom_range(0, 400)),
              1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'b0, 0);
    end
    run_job(10'd1020, 300, 1'b1, 0, 1'b0, 3);  // reset mid-STREAM
    run_job(10'd3,    130, 1'b0, 0, 1'b0, 0);  // clean job after reset

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
